// File: rtl/colocador_barcos.sv
// colocador_barcos: ship-placement controller feeding registroB.
// Moves a cursor over a 5x5 board, checks each ship's fit and overlap, then
// streams one write per occupied cell (casilla/tipo/enable). Ships are placed
// largest first, from num_barcos down to 1; tipo is the current ship size.
module colocador_barcos #(
  parameter int N        = 5,
  parameter int MAX_TIPO = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       num_barcos,
  input  logic             btn_up,
  input  logic             btn_down,
  input  logic             btn_left,
  input  logic             btn_right,
  input  logic             btn_rot,
  input  logic             btn_ok,
  output logic [4:0]       casilla,
  output logic [2:0]       tipo,
  output logic             enable,
  output logic             vertical,
  output logic [N*N-1:0]   ocupado,
  output logic             valido,
  output logic             error,
  output logic             done
);

  localparam int CELLS = N * N;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PLACE = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           state_q;
  logic [2:0]       fila_q;
  logic [2:0]       col_q;
  logic             vertical_q;
  logic [2:0]       tipo_q;
  logic [CELLS-1:0] ocupado_q;
  logic [4:0]       casilla_q;
  logic             enable_q;
  logic             error_q;
  logic             done_q;
  logic [4:0]       anchor_q;
  logic             wvert_q;
  logic [2:0]       k_q;

  // Cursor-derived signals
  logic [4:0]       cursor_idx;
  logic [5:0]       step_place;
  logic [5:0]       cell_idx [MAX_TIPO];
  logic [CELLS-1:0] cover_mask;
  logic             fits;

  // Next cursor after move/rotate pulses
  logic [2:0]       fila_d;
  logic [2:0]       col_d;
  logic             vertical_d;
  logic [4:0]       cursor_idx_d;

  // Session start and write-phase helpers
  logic [2:0]       tipo_start;
  logic [4:0]       wstep;
  logic [2:0]       k_d;
  logic             last_cell;
  logic [CELLS-1:0] write_bit;

  assign cursor_idx = 5'(fila_q) * 5'd5 + 5'(col_q);
  assign step_place = vertical_q ? 6'd5 : 6'd1;

  // Index of every cell a ship of maximum size would cover from the cursor;
  // 6 bits so out-of-board candidates never alias onto real cells.
  generate
    for (genvar gi = 0; gi < MAX_TIPO; gi++) begin : g_cells
      assign cell_idx[gi] = {1'b0, cursor_idx} + 6'(gi) * step_place;
    end
  endgenerate

  // Occupancy mask of the first tipo cells from the cursor
  always_comb begin
    cover_mask = '0;
    for (int i = 0; i < MAX_TIPO; i++) begin
      if ((3'(i) < tipo_q) && (cell_idx[i] < 6'(CELLS))) begin
        cover_mask[cell_idx[i][4:0]] = 1'b1;
      end
    end
  end

  // The ship's far end must stay on the board: start + size <= N
  assign fits = vertical_q ? (({1'b0, fila_q} + {1'b0, tipo_q}) <= 4'(N))
                           : (({1'b0, col_q}  + {1'b0, tipo_q}) <= 4'(N));

  assign valido = (state_q == S_PLACE) && fits && ~|(cover_mask & ocupado_q);

  // Cursor step: one move per cycle with priority up > down > left > right
  always_comb begin
    fila_d = fila_q;
    col_d  = col_q;
    if (btn_up) begin
      if (fila_q != 3'd0) fila_d = fila_q - 3'd1;
    end else if (btn_down) begin
      if (fila_q != 3'(N - 1)) fila_d = fila_q + 3'd1;
    end else if (btn_left) begin
      if (col_q != 3'd0) col_d = col_q - 3'd1;
    end else if (btn_right) begin
      if (col_q != 3'(N - 1)) col_d = col_q + 3'd1;
    end
  end

  assign vertical_d   = vertical_q ^ btn_rot;
  assign cursor_idx_d = 5'(fila_d) * 5'd5 + 5'(col_d);

  assign tipo_start = (num_barcos == 3'd0)           ? 3'd1 :
                      (num_barcos > 3'(MAX_TIPO))    ? 3'(MAX_TIPO) :
                      num_barcos;

  assign wstep     = wvert_q ? 5'd5 : 5'd1;
  assign k_d       = k_q + 3'd1;
  assign last_cell = (k_q == (tipo_q - 3'd1));
  assign write_bit = {{(CELLS - 1){1'b0}}, 1'b1} << casilla_q;

  // Placement FSM with all outputs registered
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      fila_q     <= '0;
      col_q      <= '0;
      vertical_q <= 1'b0;
      tipo_q     <= '0;
      ocupado_q  <= '0;
      casilla_q  <= '0;
      enable_q   <= 1'b0;
      error_q    <= 1'b0;
      done_q     <= 1'b0;
      anchor_q   <= '0;
      wvert_q    <= 1'b0;
      k_q        <= '0;
    end else begin
      error_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          enable_q   <= 1'b0;
          done_q     <= 1'b0;
          casilla_q  <= '0;
          ocupado_q  <= '0;
          fila_q     <= '0;
          col_q      <= '0;
          vertical_q <= 1'b0;
          if (start) begin
            tipo_q  <= tipo_start;
            state_q <= S_PLACE;
          end
        end

        S_PLACE: begin
          if (btn_ok) begin
            // btn_ok wins the cycle; same-cycle moves and rotate are dropped
            if (valido) begin
              anchor_q  <= cursor_idx;
              wvert_q   <= vertical_q;
              k_q       <= '0;
              casilla_q <= cursor_idx;
              enable_q  <= 1'b1;
              state_q   <= S_WRITE;
            end else begin
              error_q <= 1'b1;
            end
          end else begin
            fila_q     <= fila_d;
            col_q      <= col_d;
            vertical_q <= vertical_d;
            casilla_q  <= cursor_idx_d;
          end
        end

        S_WRITE: begin
          // The cell on the bus this cycle becomes occupied at this edge
          ocupado_q <= ocupado_q | write_bit;
          if (last_cell) begin
            enable_q <= 1'b0;
            if (tipo_q == 3'd1) begin
              done_q    <= 1'b1;
              casilla_q <= '0;
              state_q   <= S_DONE;
            end else begin
              tipo_q    <= tipo_q - 3'd1;
              casilla_q <= cursor_idx;
              state_q   <= S_PLACE;
            end
          end else begin
            k_q       <= k_d;
            casilla_q <= anchor_q + 5'(k_d) * wstep;
          end
        end

        S_DONE: begin
          enable_q  <= 1'b0;
          casilla_q <= '0;
          done_q    <= 1'b1;
          if (start) begin
            tipo_q     <= tipo_start;
            ocupado_q  <= '0;
            fila_q     <= '0;
            col_q      <= '0;
            vertical_q <= 1'b0;
            done_q     <= 1'b0;
            state_q    <= S_PLACE;
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign casilla  = casilla_q;
  assign tipo     = tipo_q;
  assign enable   = enable_q;
  assign vertical = vertical_q;
  assign ocupado  = ocupado_q;
  assign error    = error_q;
  assign done     = done_q;

endmodule

// File: doc/colocador_barcos.md
Name: colocador_barcos

Overview:
- Ship-placement controller sitting directly upstream of registroB.
- Moves a cursor over the 5x5 board and validates each ship's position and orientation.
- For every accepted ship, streams one write per occupied cell on casilla/tipo/enable into registroB.
- Places ships of size num_barcos down to 1, largest first; tipo equals ship size.

Parameters:
- N, 5, board side length. Fixed at 5 because casilla is 5 bits.
- MAX_TIPO, 5, largest ship size and upper clamp for num_barcos.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-low
- start  in  1  one-cycle pulse; begins a placement session
- num_barcos  in  3  number of ships; sampled on start
- btn_up/btn_down/btn_left/btn_right  in  1 each  one-cycle cursor-move pulses
- btn_rot  in  1  one-cycle pulse; toggles orientation
- btn_ok  in  1  one-cycle pulse; requests placement at the cursor
- casilla  out  5  cursor index in PLACE, cell being written in WRITE; index = fila*5+col
- tipo  out  3  current ship size
- enable  out  1  write strobe to registroB, one cell per cycle
- vertical  out  1  current orientation (0 = horizontal)
- ocupado  out  25  occupancy map; bit i set means cell i is taken
- valido  out  1  current cursor/orientation/size placement is legal (combinational)
- error  out  1  one-cycle pulse on rejected btn_ok
- done  out  1  all ships placed

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; casilla=0, tipo=0, enable=0, vertical=0, ocupado=0, error=0, done=0; fila=col=0.
- States: IDLE, PLACE, WRITE, DONE.
- IDLE
  - start=1 -> PLACE next cycle.
  - Clear ocupado and the cursor; vertical=0.
  - Set tipo = clamp(num_barcos): 0 becomes 1, >5 becomes 5.
- PLACE, cursor movement:
  - Cursor moves one step per pulse and saturates at the edges, with no wrap.
  - If several move pulses arrive in one cycle, only the highest-priority one applies: up > down > left > right.
  - btn_rot toggles vertical; it may coincide with a move pulse and both apply.
- PLACE, validity (valido):
  - Horizontal: col+tipo-1 <= 4. Vertical: fila+tipo-1 <= 4.
  - None of the tipo covered cells may be set in ocupado.
- PLACE, btn_ok:
  - btn_ok has priority over moves/rot in the same cycle; those pulses are dropped.
  - btn_ok with valido=1 -> WRITE; latch anchor, orientation and tipo; cell counter k=0.
  - btn_ok with valido=0 -> error=1 for exactly one cycle; stay in PLACE; nothing else changes.
- WRITE
  - Exactly tipo consecutive cycles with enable=1.
  - casilla = anchor+k for horizontal, anchor+5k for vertical, k=0..tipo-1.
  - tipo is held constant throughout.
  - Each written cell's ocupado bit sets on the same clock edge that ends its enable cycle.
  - All buttons are ignored.
  - After the last cell: if tipo==1 -> DONE, else tipo decrements and the state returns to PLACE.
  - Cursor and vertical are kept on return to PLACE.
- DONE
  - done=1, enable=0, casilla=0.
  - ocupado is held until start, which re-enters IDLE behaviour and begins a new session.
- Latency: btn_ok edge to first enable is 1 cycle.
- start outside IDLE/DONE is ignored.
- Reset mid-WRITE: enable drops immediately (asynchronously); the partial ship is discarded.
- Arithmetic: fila, col and k are 3-bit; casilla is computed at 5 bits. Legal placements never exceed index 24.

Test Plan:
- Reset then start, num_barcos=1, btn_ok at (0,0) -> one cycle of enable=1, casilla=0, tipo=1; done=1 next cycle; ocupado=25'h1.
- start, num_barcos=3; right x2; btn_ok -> enable for 3 cycles with casilla=2,3,4 and tipo=3; then tipo=2 in PLACE.
- Continue that session: btn_rot, down; btn_ok at (1,2) -> casilla=7,12, tipo=2. Then btn_ok at (1,2) again for tipo=1 -> error pulse, no enable.
- Cursor at (0,3), tipo=3 horizontal: btn_ok -> valido=0, error=1 for one cycle. Then btn_rot, btn_ok -> casilla=3,8,13.
- Saturation: 6 left pulses at col 0 -> col stays 0. up and right in the same cycle -> only up applies.
- Assert rst=0 on the 2nd WRITE cycle -> enable=0 immediately, ocupado=0, state IDLE. num_barcos=0 on start -> tipo=1.
